multi_stepctl: RTL and testbench
================================

# multi_stepctl

Multi-channel, parametrised closed-loop step controller. It accepts signed tick-count moves through a valid/ready command port and runs each motor channel independently until that channel's encoder has produced the requested number of rising edges. Each running channel drives a motor enable, a direction and a speed setpoint into a downstream per-channel speed loop. A channel terminates early on abort or encoder stall.

## Interface
- NCH, 2: number of motor channels (1..8)
- CHW, 1: width of cmd_ch; 2^CHW ≥ NCH
- CW, 16: tick-count width; cmd_ticks is two's complement
- SW, 16: speed setpoint width
- STALL_W, 24: stall timer width
- STALL_CYCLES, 24'd5_000_000: clk cycles without an encoder edge before a stall; 0 disables stall detection
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted (combinational)
- cmd_ch  in  CHW  target channel
- cmd_ticks  in  CW  signed move length; sign selects direction
- cmd_speed  in  SW  speed setpoint for the move
- abort  in  NCH  per-channel stop request, level-sampled
- encoder  in  NCH  raw asynchronous encoder pulses
- motor_en  out  NCH  channel driving
- dir  out  NCH  1 = reverse (negative ticks)
- speed_set  out  NCH*SW  channel i at bits [i*SW +: SW]
- busy  out  NCH  channel in RUN
- done  out  NCH  1-cycle pulse on any termination
- stall  out  NCH  sticky: last move ended by stall

## Operation
- cmd_ready = (cmd_ch < NCH) && !busy[cmd_ch]. A command is accepted on a clock edge where cmd_valid && cmd_ready.
- On accept for channel c:
  - remaining[c] = |cmd_ticks|, computed in CW bits unsigned. The most negative value gives 2^(CW-1); no overflow.
  - dir[c] = cmd_ticks[CW-1]; speed latched; stall[c] cleared; stall timer cleared.
- Magnitude 0: the channel stays IDLE, done[c] pulses on the next cycle, motor_en stays 0, and dir still updates.
- Per-channel FSM:
  - IDLE: motor_en = 0, busy = 0, speed_set = 0. Go to RUN on accept with nonzero magnitude.
  - RUN: motor_en = 1, busy = 1, speed_set = latched speed.
    - Each detected pulse decrements remaining.
    - A pulse with remaining == 1 goes to IDLE.
    - abort[c] = 1 goes to IDLE.
    - Stall timer reaching STALL_CYCLES goes to IDLE and sets stall[c].
  - Every RUN→IDLE transition pulses done[c] for exactly one cycle, registered and coincident with the IDLE cycle.
- Encoder path, per channel: 2-flop synchroniser plus one history flop. pulse = sync & ~hist, i.e. rising edges only. The synchronisers run in every state; pulses seen in IDLE are ignored.
- Stall timer:
  - Increments every RUN cycle and clears on pulse.
  - When the timer equals STALL_CYCLES-1 and no pulse occurs, the channel stalls on that edge.
  - The timer saturates and never wraps.
- Simultaneous events:
  - Final pulse together with abort or stall: normal completion, stall stays 0.
  - Abort together with stall: abort wins, stall stays 0.
  - Abort to an IDLE channel is ignored. If it coincides with an accept on that channel, the command is taken.
- Channels are fully independent. Commands to other channels are accepted while one channel runs.
- dir holds its last value in IDLE.

## Timing
- Reset:
  - motor_en, busy, done, stall, dir, and all speed_set bits are 0.
  - remaining, timers and synchronisers are 0; all FSMs are IDLE.
  - cmd_ready is 1 for any valid cmd_ch.
  - Asserting rst mid-move drops motor_en immediately (asynchronously).
- Accept at edge k: busy, motor_en, dir and speed_set are valid after edge k. cmd_ready for that channel falls combinationally after edge k.
- An encoder rising edge is counted 3 clk edges after it is set up at the input (2 sync + edge detect).
- Final pulse counted at edge k: motor_en = 0, busy = 0 and done = 1 after edge k. done returns to 0 after edge k+1. A new command to that channel is accepted from edge k+1.
- Minimum encoder high and low time is 2 clk periods; edges faster than that are not guaranteed to count.

## Test plan
- Channel 0, cmd_ticks = +5, speed = 720, five encoder pulses:
  - motor_en[0] = 1 for the whole move, dir[0] = 0, speed_set[0] = 720.
  - done[0] pulses 3 edges after the 5th rising edge.
  - busy and speed_set return to 0.
- Channel 1, cmd_ticks = -3 (16'hFFFD): dir[1] = 1 and the move ends after 3 pulses. Separately, cmd_ticks = 16'h8000 requires 32768 pulses.
- cmd_ticks = 0: done pulses on the next cycle, motor_en never asserts, cmd_ready stays 1.
- STALL_CYCLES = 100, command +10, 2 pulses then silence: the channel goes IDLE 100 cycles after the last counted pulse, stall = 1 and done pulses. The next accept clears stall.
- Abort and concurrency: channel 0 running +100 and channel 1 running +4 at the same time:
  - Channel 0 must refuse a second command (cmd_ready = 0) while channel 1 accepts its command.
  - abort[0] ends channel 0 with done and stall = 0.
  - Abort on the same edge as channel 1's final pulse gives normal completion.
- Assert rst mid-move: all outputs go 0 at once. After release, cmd_ready = 1 and encoder pulses cause no motion.

Source files
------------

// File: rtl/multi_stepctl.sv
// multi_stepctl: multi-channel closed-loop step controller.
// Each channel accepts a signed tick-count move, enables its motor with the
// requested direction and speed, and counts synchronised encoder rising edges
// until the move completes, is aborted, or the encoder stalls.
module multi_stepctl #(
    parameter int                 NCH          = 2,
    parameter int                 CHW          = 1,
    parameter int                 CW           = 16,
    parameter int                 SW           = 16,
    parameter int                 STALL_W      = 24,
    parameter logic [STALL_W-1:0] STALL_CYCLES = 24'd5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CHW-1:0]    cmd_ch,
    input  logic [CW-1:0]     cmd_ticks,
    input  logic [SW-1:0]     cmd_speed,
    input  logic [NCH-1:0]    abort,
    input  logic [NCH-1:0]    encoder,
    output logic [NCH-1:0]    motor_en,
    output logic [NCH-1:0]    dir,
    output logic [NCH*SW-1:0] speed_set,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    stall
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Timer value on which a silent channel is declared stalled.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_CYCLES - STALL_W'(1);

    // Unsigned magnitude of a two's complement tick count. The most negative
    // value maps onto 2^(CW-1), which still fits in CW unsigned bits.
    function automatic logic [CW-1:0] abs_ticks(input logic signed [CW-1:0] t);
        logic [CW-1:0] u;
        u = t;
        return u[CW-1] ? (~u + CW'(1)) : u;
    endfunction

    logic signed [CW-1:0] ticks_s;
    logic [CW-1:0]        cmd_mag;

    assign ticks_s = cmd_ticks;
    assign cmd_mag = abs_ticks(ticks_s);

    // A command is takeable when it addresses an existing, idle channel.
    always_comb begin
        cmd_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cmd_ch == CHW'(i)) begin
                cmd_ready = !busy[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t              state_q;
        state_t              state_d;
        logic [CW-1:0]       rem_q;
        logic [SW-1:0]       spd_q;
        logic [STALL_W-1:0]  tmr_q;
        logic                sync1_q;
        logic                sync2_q;
        logic                hist_q;
        logic                dir_q;
        logic                done_q;
        logic                stall_q;
        logic                pulse;
        logic                acc;
        logic                fin;
        logic                stall_hit;
        logic                end_move;
        logic                end_stall;

        assign pulse     = sync2_q & ~hist_q;
        assign acc       = cmd_valid && cmd_ready && (cmd_ch == CHW'(g));
        assign fin       = pulse && (rem_q == CW'(1));
        assign stall_hit = (STALL_CYCLES != '0) && (tmr_q == STALL_LAST) && !pulse;

        // State register; reset drops the channel to IDLE immediately.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next state: final pulse beats abort, abort beats stall.
        always_comb begin
            state_d   = state_q;
            end_move  = 1'b0;
            end_stall = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc && (cmd_mag != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fin || abort[g]) begin
                        state_d  = ST_IDLE;
                        end_move = 1'b1;
                    end else if (stall_hit) begin
                        state_d   = ST_IDLE;
                        end_move  = 1'b1;
                        end_stall = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Encoder synchroniser, move bookkeeping, stall timer and status flags.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                hist_q  <= 1'b0;
                rem_q   <= '0;
                spd_q   <= '0;
                tmr_q   <= '0;
                dir_q   <= 1'b0;
                done_q  <= 1'b0;
                stall_q <= 1'b0;
            end else begin
                sync1_q <= encoder[g];
                sync2_q <= sync1_q;
                hist_q  <= sync2_q;
                done_q  <= end_move || (acc && (cmd_mag == '0));
                if (acc) begin
                    rem_q   <= cmd_mag;
                    dir_q   <= ticks_s[CW-1];
                    spd_q   <= cmd_speed;
                    stall_q <= 1'b0;
                    tmr_q   <= '0;
                end else if (state_q == ST_RUN) begin
                    if (pulse) begin
                        rem_q <= rem_q - CW'(1);
                        tmr_q <= '0;
                    end else if (tmr_q != '1) begin
                        tmr_q <= tmr_q + STALL_W'(1);
                    end
                    if (end_stall) begin
                        stall_q <= 1'b1;
                    end
                end
            end
        end

        assign motor_en[g]            = (state_q == ST_RUN);
        assign busy[g]                = (state_q == ST_RUN);
        assign dir[g]                 = dir_q;
        assign done[g]                = done_q;
        assign stall[g]               = stall_q;
        assign speed_set[g*SW +: SW]  = (state_q == ST_RUN) ? spd_q : '0;
    end

endmodule

// File: tb/tb_multi_stepctl.sv
// Directed testbench for multi_stepctl: single moves, negative and zero
// moves, stall, abort, concurrency, asynchronous reset, and the most negative
// tick count on a narrow-width instance.
module tb_multi_stepctl;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Main instance: two channels, short stall window.
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_ch;
    logic [15:0] cmd_ticks;
    logic [15:0] cmd_speed;
    logic [1:0]  abort;
    logic [1:0]  enc;
    logic [1:0]  motor_en;
    logic [1:0]  dir;
    logic [31:0] speed_set;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  stall;

    multi_stepctl #(
        .NCH(2), .CHW(1), .CW(16), .SW(16), .STALL_W(24), .STALL_CYCLES(24'd100)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_ticks(cmd_ticks), .cmd_speed(cmd_speed),
        .abort(abort), .encoder(enc), .motor_en(motor_en), .dir(dir),
        .speed_set(speed_set), .busy(busy), .done(done), .stall(stall)
    );

    // Narrow instance: 4-bit ticks, stall detection disabled.
    logic        n_cmd_valid;
    logic        n_cmd_ready;
    logic [0:0]  n_cmd_ch;
    logic [3:0]  n_cmd_ticks;
    logic [15:0] n_cmd_speed;
    logic [0:0]  n_abort;
    logic [0:0]  n_enc;
    logic [0:0]  n_motor_en;
    logic [0:0]  n_dir;
    logic [15:0] n_speed_set;
    logic [0:0]  n_busy;
    logic [0:0]  n_done;
    logic [0:0]  n_stall;

    multi_stepctl #(
        .NCH(1), .CHW(1), .CW(4), .SW(16), .STALL_W(4), .STALL_CYCLES(4'd0)
    ) dut_n (
        .clk(clk), .rst(rst), .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready),
        .cmd_ch(n_cmd_ch), .cmd_ticks(n_cmd_ticks), .cmd_speed(n_cmd_speed),
        .abort(n_abort), .encoder(n_enc), .motor_en(n_motor_en), .dir(n_dir),
        .speed_set(n_speed_set), .busy(n_busy), .done(n_done), .stall(n_stall)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Channel 2 selects the narrow instance's encoder.
    task automatic set_enc(input int ch, input logic v);
        if (ch == 2) n_enc[0] = v;
        else enc[ch] = v;
    endtask

    task automatic pulse(input int ch);
        set_enc(ch, 1'b1);
        step(2);
        set_enc(ch, 1'b0);
        step(2);
    endtask

    // Final pulse of a move on the main instance: counted on the 3rd edge.
    task automatic last_pulse(input int ch, input string tag);
        set_enc(ch, 1'b1);
        step(2);
        check({tag, "_busy_before"}, 32'(busy[ch]), 1);
        step(1);
        check({tag, "_done"}, 32'(done[ch]), 1);
        check({tag, "_en_off"}, 32'(motor_en[ch]), 0);
        check({tag, "_busy_off"}, 32'(busy[ch]), 0);
        set_enc(ch, 1'b0);
        step(1);
        check({tag, "_done_clear"}, 32'(done[ch]), 0);
    endtask

    task automatic send(input int ch, input logic [15:0] ticks, input logic [15:0] spd);
        cmd_ch    = 1'(ch);
        cmd_ticks = ticks;
        cmd_speed = spd;
        cmd_valid = 1'b1;
        #1;
        check("send_ready", 32'(cmd_ready), 1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ch = '0; cmd_ticks = '0; cmd_speed = '0;
        abort = '0; enc = '0;
        n_cmd_valid = 1'b0; n_cmd_ch = '0; n_cmd_ticks = '0; n_cmd_speed = '0;
        n_abort = '0; n_enc = '0;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        check("rst_en", 32'(motor_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_speed", speed_set, 0);
        cmd_ch = 1'b1;
        #1 check("rst_ready_ch1", 32'(cmd_ready), 1);
        step(1);

        // Channel 0, +5 ticks at speed 720
        send(0, 16'd5, 16'd720);
        check("t1_en", 32'(motor_en[0]), 1);
        check("t1_dir", 32'(dir[0]), 0);
        check("t1_speed", 32'(speed_set[15:0]), 720);
        check("t1_ready_busy", 32'(cmd_ready), 0);
        for (int i = 0; i < 4; i++) begin
            pulse(0);
            check("t1_en_mid", 32'(motor_en[0]), 1);
        end
        last_pulse(0, "t1");
        check("t1_speed_off", speed_set, 0);

        // Channel 1, -3 ticks
        send(1, 16'hFFFD, 16'd100);
        check("t2_dir", 32'(dir[1]), 1);
        check("t2_speed", 32'(speed_set[31:16]), 100);
        pulse(1);
        pulse(1);
        check("t2_busy_mid", 32'(busy[1]), 1);
        last_pulse(1, "t2");
        check("t2_dir_hold", 32'(dir[1]), 1);

        // Zero-length move
        send(0, 16'd0, 16'd50);
        check("t3_done", 32'(done[0]), 1);
        check("t3_en", 32'(motor_en[0]), 0);
        check("t3_ready", 32'(cmd_ready), 1);
        step(1);
        check("t3_done_clear", 32'(done[0]), 0);

        // Stall: two pulses then silence, STALL_CYCLES = 100
        send(0, 16'd10, 16'd300);
        pulse(0);
        pulse(0);
        step(98);
        check("t4_busy_pre", 32'(busy[0]), 1);
        check("t4_stall_pre", 32'(stall[0]), 0);
        step(1);
        check("t4_busy_post", 32'(busy[0]), 0);
        check("t4_stall", 32'(stall[0]), 1);
        check("t4_done", 32'(done[0]), 1);
        step(1);
        check("t4_done_clear", 32'(done[0]), 0);
        check("t4_stall_sticky", 32'(stall[0]), 1);
        send(0, 16'd3, 16'd10);
        check("t4_stall_cleared", 32'(stall[0]), 0);
        abort[0] = 1'b1;
        step(1);
        abort[0] = 1'b0;
        check("t4_abort_idle", 32'(busy[0]), 0);

        // Concurrency and abort
        send(0, 16'd100, 16'd500);
        cmd_ch = 1'b0; cmd_ticks = 16'd7; cmd_speed = 16'd77; cmd_valid = 1'b1;
        #1 check("t5_refuse", 32'(cmd_ready), 0);
        step(1);
        cmd_valid = 1'b0;
        check("t5_speed_kept", 32'(speed_set[15:0]), 500);
        send(1, 16'd4, 16'd600);
        check("t5_both_busy", 32'(busy), 3);
        for (int i = 0; i < 3; i++) pulse(1);
        abort[0] = 1'b1;
        step(1);
        abort[0] = 1'b0;
        check("t5_abort_done", 32'(done[0]), 1);
        check("t5_abort_busy", 32'(busy[0]), 0);
        check("t5_abort_stall", 32'(stall[0]), 0);
        check("t5_ch1_running", 32'(busy[1]), 1);
        enc[1] = 1'b1;
        step(2);
        abort[1] = 1'b1;
        step(1);
        abort[1] = 1'b0;
        enc[1] = 1'b0;
        check("t5_fin_abort_done", 32'(done[1]), 1);
        check("t5_fin_abort_busy", 32'(busy[1]), 0);
        check("t5_fin_abort_stall", 32'(stall[1]), 0);
        step(1);
        // Abort held on an idle channel during accept: the command is taken.
        abort[0] = 1'b1;
        send(0, 16'd2, 16'd40);
        abort[0] = 1'b0;
        check("t5_abort_accept", 32'(busy[0]), 1);
        pulse(0);
        last_pulse(0, "t5b");

        // Asynchronous reset mid-move
        send(0, 16'hFFEC, 16'd900);
        check("t6_dir", 32'(dir[0]), 1);
        pulse(0);
        #2 rst = 1'b1;
        #1;
        check("t6_en", 32'(motor_en), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_speed", speed_set, 0);
        check("t6_dir_rst", 32'(dir), 0);
        @(negedge clk);
        rst = 1'b0;
        cmd_ch = 1'b0;
        #1 check("t6_ready", 32'(cmd_ready), 1);
        pulse(0);
        pulse(0);
        check("t6_no_motion", 32'(motor_en), 0);

        // Most negative tick count on the 4-bit instance: 8 pulses
        n_cmd_ch = 1'b0; n_cmd_ticks = 4'h8; n_cmd_speed = 16'd33; n_cmd_valid = 1'b1;
        #1 check("n_ready", 32'(n_cmd_ready), 1);
        step(1);
        n_cmd_valid = 1'b0;
        check("n_busy", 32'(n_busy), 1);
        check("n_dir", 32'(n_dir), 1);
        check("n_speed", 32'(n_speed_set), 33);
        step(20);
        check("n_no_stall", 32'(n_busy), 1);
        for (int i = 0; i < 7; i++) pulse(2);
        check("n_busy_7", 32'(n_busy), 1);
        n_enc[0] = 1'b1;
        step(3);
        check("n_done", 32'(n_done), 1);
        check("n_busy_off", 32'(n_busy), 0);
        check("n_stall", 32'(n_stall), 0);
        n_enc[0] = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
